// File: rtl/multi_clk_div_if.sv
// Control and status bundle for the multi-channel clock divider.
// The master drives enables, sync and config writes; the slave returns the divided clocks and status.
interface multi_clk_div_if #(
   parameter  int unsigned NUM_CH = 4,
   parameter  int unsigned CNT_W  = 32,
   localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
   logic [NUM_CH-1:0] en;
   logic              sync;
   logic              cfg_we;
   logic [CH_W-1:0]   cfg_ch;
   logic [CNT_W-1:0]  cfg_half;
   logic [NUM_CH-1:0] divided_clk;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] cfg_pending;

   modport master (
      output en, sync, cfg_we, cfg_ch, cfg_half,
      input  divided_clk, tick, cfg_pending
   );

   modport slave (
      input  en, sync, cfg_we, cfg_ch, cfg_half,
      output divided_clk, tick, cfg_pending
   );
endinterface

// File: rtl/multi_clk_div.sv
// Multi-channel programmable clock divider / tick generator.
// Each channel toggles divided_clk every H+1 enabled cycles; new H is shadowed and applied at a period boundary.
module multi_clk_div #(
   parameter  int unsigned NUM_CH       = 4,
   parameter  int unsigned CNT_W        = 32,
   parameter  int unsigned DEFAULT_HALF = 4999999,
   localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic           clk,
   input  logic           rst_n,
   multi_clk_div_if.slave bus
);

   localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);

   logic [CNT_W-1:0]  cnt_q    [NUM_CH];
   logic [CNT_W-1:0]  cnt_d    [NUM_CH];
   logic [CNT_W-1:0]  active_q [NUM_CH];
   logic [CNT_W-1:0]  active_d [NUM_CH];
   logic [CNT_W-1:0]  shadow_q [NUM_CH];
   logic [CNT_W-1:0]  shadow_d [NUM_CH];
   logic [NUM_CH-1:0] dclk_q, dclk_d;
   logic [NUM_CH-1:0] tick_q, tick_d;
   logic [NUM_CH-1:0] pend_q, pend_d;
   logic [NUM_CH-1:0] wr_hit_c;
   logic [NUM_CH-1:0] term_c;

   // Out-of-range channel indices never match, so such writes are dropped.
   always_comb begin
      wr_hit_c = '0;
      term_c   = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         wr_hit_c[i] = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
         term_c[i]   = bus.en[i] && (cnt_q[i] == active_q[i]) && !bus.sync;
      end
   end

   // Per-channel next state; sync overrides everything, then enabled counting, then frozen.
   always_comb begin
      dclk_d = dclk_q;
      tick_d = '0;
      pend_d = pend_q;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         cnt_d[i]    = cnt_q[i];
         active_d[i] = active_q[i];
         shadow_d[i] = wr_hit_c[i] ? bus.cfg_half : shadow_q[i];

         if (bus.sync) begin
            cnt_d[i]    = '0;
            dclk_d[i]   = 1'b0;
            active_d[i] = wr_hit_c[i] ? bus.cfg_half : shadow_q[i];
            pend_d[i]   = 1'b0;
         end else if (term_c[i]) begin
            // Boundary uses the shadow as it stood before any same-cycle write.
            cnt_d[i]    = '0;
            dclk_d[i]   = ~dclk_q[i];
            tick_d[i]   = ~dclk_q[i];
            active_d[i] = shadow_q[i];
            pend_d[i]   = wr_hit_c[i];
         end else if (bus.en[i]) begin
            cnt_d[i]    = cnt_q[i] + CNT_W'(1);
            pend_d[i]   = pend_q[i] | wr_hit_c[i];
         end else if (wr_hit_c[i]) begin
            active_d[i] = bus.cfg_half;
            pend_d[i]   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_q[i]    <= '0;
            active_q[i] <= RST_HALF;
            shadow_q[i] <= RST_HALF;
         end
         dclk_q <= '0;
         tick_q <= '0;
         pend_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_q[i]    <= cnt_d[i];
            active_q[i] <= active_d[i];
            shadow_q[i] <= shadow_d[i];
         end
         dclk_q <= dclk_d;
         tick_q <= tick_d;
         pend_q <= pend_d;
      end
   end

   assign bus.divided_clk = dclk_q;
   assign bus.tick        = tick_q;
   assign bus.cfg_pending = pend_q;

endmodule

// File: tb/tb_multi_clk_div.sv
// Bench for multi_clk_div: directed scenarios plus random traffic against a behavioural channel model.
module tb_multi_clk_div;
   localparam int unsigned NUM_CH = 3;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned DEF_H  = 3;
   localparam int unsigned MODV   = 1 << CNT_W;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   multi_clk_div_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

   multi_clk_div #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_HALF(DEF_H)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural model: elapsed count since last toggle, applied and shadowed half-periods.
   int unsigned m_elapsed [NUM_CH];
   int unsigned m_half    [NUM_CH];
   int unsigned m_next    [NUM_CH];
   bit          m_lvl     [NUM_CH];
   bit          m_tick    [NUM_CH];
   bit          m_pend    [NUM_CH];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_elapsed[i] = 0; m_half[i] = DEF_H; m_next[i] = DEF_H;
         m_lvl[i] = 0; m_tick[i] = 0; m_pend[i] = 0;
      end
   endtask

   task automatic model_step();
      int unsigned wch = bus.cfg_ch;
      int unsigned wval = bus.cfg_half;
      for (int i = 0; i < NUM_CH; i++) begin
         bit hit = bus.cfg_we && (wch == i);
         m_tick[i] = 0;
         if (bus.sync) begin
            m_elapsed[i] = 0; m_lvl[i] = 0; m_pend[i] = 0;
            m_half[i] = hit ? wval : m_next[i];
         end else if (bus.en[i]) begin
            if (m_elapsed[i] == m_half[i]) begin
               m_tick[i] = !m_lvl[i];
               m_lvl[i] = !m_lvl[i];
               m_elapsed[i] = 0;
               m_half[i] = m_next[i];
               m_pend[i] = hit;
            end else begin
               m_elapsed[i] = (m_elapsed[i] + 1) % MODV;
               if (hit) m_pend[i] = 1;
            end
         end else if (hit) begin
            m_half[i] = wval;
            m_pend[i] = 0;
         end
         if (hit) m_next[i] = wval;
      end
   endtask

   function automatic logic [31:0] pack(input int sel);
      logic [31:0] v = '0;
      for (int i = 0; i < NUM_CH; i++)
         v[i] = (sel == 0) ? m_lvl[i] : (sel == 1) ? m_tick[i] : m_pend[i];
      return v;
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
      model_step();
      check("dclk", 32'(bus.divided_clk), pack(0));
      check("tick", 32'(bus.tick), pack(1));
      check("pend", 32'(bus.cfg_pending), pack(2));
   endtask

   task automatic idle_inputs();
      bus.sync = 0; bus.cfg_we = 0; bus.cfg_ch = '0; bus.cfg_half = '0;
   endtask

   task automatic write_cfg(input int unsigned ch, input int unsigned half);
      bus.cfg_we = 1; bus.cfg_ch = 2'(ch); bus.cfg_half = 8'(half);
      cycle();
      bus.cfg_we = 0;
   endtask

   initial begin
      bit found;
      idle_inputs();
      bus.en = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_dclk", 32'(bus.divided_clk), 32'h0);
      check("rst_tick", 32'(bus.tick), 32'h0);
      check("rst_pend", 32'(bus.cfg_pending), 32'h0);
      bus.en = 3'b111;
      rst_n = 1;

      // Default H=3: first rise on the 4th edge, fall on the 8th.
      repeat (3) cycle();
      check("t1_pre_rise", 32'(bus.divided_clk), 32'h0);
      cycle();
      check("t1_rise", 32'(bus.divided_clk), 32'h7);
      check("t1_tick", 32'(bus.tick), 32'h7);
      cycle();
      check("t1_tick_clr", 32'(bus.tick), 32'h0);
      repeat (3) cycle();
      check("t1_fall", 32'(bus.divided_clk), 32'h0);

      // Mid-period reprogram of ch0 to H=1.
      cycle();
      write_cfg(0, 1);
      check("t2_pend_set", 32'(bus.cfg_pending), 32'h1);
      repeat (12) cycle();
      check("t2_pend_clr", 32'(bus.cfg_pending), 32'h0);

      // Freeze ch0 while high, reprogram to H=0, resume.
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (bus.divided_clk[0]) found = 1;
         else cycle();
      end
      check("t3_found_high", 32'(found), 32'h1);
      bus.en = 3'b110;
      repeat (10) cycle();
      check("t3_frozen", 32'(bus.divided_clk[0]), 32'h1);
      write_cfg(0, 0);
      check("t3_no_pend", 32'(bus.cfg_pending[0]), 32'h0);
      bus.en = 3'b111;
      repeat (8) cycle();

      // Phase resync of all channels.
      bus.sync = 1;
      cycle();
      bus.sync = 0;
      check("t4_sync_low", 32'(bus.divided_clk), 32'h0);
      repeat (10) cycle();

      // Out-of-range channel write is dropped.
      write_cfg(3, 5);
      check("t5_bad_ch", 32'(bus.cfg_pending), 32'h0);
      repeat (3) cycle();

      // Write ch1 in the very cycle its boundary fires.
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         if (m_elapsed[1] == m_half[1]) found = 1;
         else cycle();
      end
      check("t5_found_term", 32'(found), 32'h1);
      write_cfg(1, 2);
      check("t5_pend_kept", 32'(bus.cfg_pending[1]), 32'h1);
      repeat (16) cycle();

      // Async reset between edges with a pending write outstanding.
      write_cfg(2, 6);
      cycle();
      #3 rst_n = 0;
      #1;
      check("t6_dclk", 32'(bus.divided_clk), 32'h0);
      check("t6_tick", 32'(bus.tick), 32'h0);
      check("t6_pend", 32'(bus.cfg_pending), 32'h0);
      @(posedge clk);
      #1 rst_n = 1;
      model_reset();
      repeat (12) cycle();

      // Random traffic.
      for (int k = 0; k < 1500; k++) begin
         for (int i = 0; i < NUM_CH; i++) bus.en[i] = ($urandom_range(0, 7) != 0);
         bus.sync     = ($urandom_range(0, 49) == 0);
         bus.cfg_we   = ($urandom_range(0, 3) == 0);
         bus.cfg_ch   = 2'($urandom_range(0, 3));
         bus.cfg_half = 8'($urandom_range(0, 6));
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
